// File: rtl/state_pkg.sv
// Shared types and constants for the state_demux cell bank.
package state_pkg;
  localparam int NCELLS_C = 16;

  typedef logic [3:0] cell_t;

  localparam cell_t RESET_STATE_C = 4'b0000;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;
endpackage

// File: rtl/state_demux.sv
// Bank of 16 four-bit cell registers with indexed writes and a
// one-cell-per-cycle fill sweep.
module state_demux
  import state_pkg::*;
#(
  parameter int    NCELLS      = NCELLS_C,
  parameter cell_t RESET_STATE = RESET_STATE_C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_index,
  input  logic [3:0] wr_state,
  input  logic       clr_start,
  input  logic [3:0] clr_value,
  output logic       busy,
  output logic       err,
  output logic [3:0] c1,
  output logic [3:0] c2,
  output logic [3:0] c3,
  output logic [3:0] c4,
  output logic [3:0] c5,
  output logic [3:0] c6,
  output logic [3:0] c7,
  output logic [3:0] c8,
  output logic [3:0] c9,
  output logic [3:0] c10,
  output logic [3:0] c11,
  output logic [3:0] c12,
  output logic [3:0] c13,
  output logic [3:0] c14,
  output logic [3:0] c15,
  output logic [3:0] c16
);

  localparam logic [7:0] NCELLS_IDX = 8'(NCELLS);
  localparam logic [3:0] LAST_IDX   = 4'(NCELLS - 1);

  state_t     state;
  state_t     state_next;
  cell_t      cells [NCELLS];
  logic [3:0] sweep_idx;
  cell_t      clr_val;
  logic       wr_accept;
  logic       wr_in_range;
  logic       sweep_start;

  // Next-state and write-acceptance decode
  always_comb begin
    state_next  = state;
    wr_accept   = 1'b0;
    sweep_start = 1'b0;
    wr_in_range = (wr_index < NCELLS_IDX);
    case (state)
      IDLE: begin
        wr_accept = wr_valid;
        if (clr_start) begin
          state_next  = CLEAR;
          sweep_start = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      CLEAR: begin
        if (sweep_idx == LAST_IDX) begin
          state_next = IDLE;
        end else begin
          state_next = CLEAR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Cell array: the sweep owns the cells while in CLEAR
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCELLS; i++) begin
        cells[i] <= RESET_STATE;
      end
    end else if (state == CLEAR) begin
      cells[sweep_idx] <= clr_val;
    end else if (wr_accept && wr_in_range) begin
      cells[wr_index[3:0]] <= wr_state;
    end
  end

  // Sweep bookkeeping and the out-of-range error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_idx <= 4'd0;
      clr_val   <= RESET_STATE;
      err       <= 1'b0;
    end else begin
      err <= wr_accept && !wr_in_range;
      if (sweep_start) begin
        clr_val   <= clr_value;
        sweep_idx <= 4'd0;
      end else if ((state == CLEAR) && (sweep_idx != LAST_IDX)) begin
        sweep_idx <= sweep_idx + 4'd1;
      end
    end
  end

  assign wr_ready = (state == IDLE);
  assign busy     = (state == CLEAR);

  assign c1  = cells[0];
  assign c2  = cells[1];
  assign c3  = cells[2];
  assign c4  = cells[3];
  assign c5  = cells[4];
  assign c6  = cells[5];
  assign c7  = cells[6];
  assign c8  = cells[7];
  assign c9  = cells[8];
  assign c10 = cells[9];
  assign c11 = cells[10];
  assign c12 = cells[11];
  assign c13 = cells[12];
  assign c14 = cells[13];
  assign c15 = cells[14];
  assign c16 = cells[15];

endmodule

// File: tb/tb_state_demux.sv
// Directed self-checking bench for state_demux using immediate assertions
// against a bench-side expected cell image.
module tb_state_demux;
  logic       clk;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_index;
  logic [3:0] wr_state;
  logic       clr_start;
  logic [3:0] clr_value;
  logic       busy;
  logic       err;
  logic [3:0] c1, c2, c3, c4, c5, c6, c7, c8;
  logic [3:0] c9, c10, c11, c12, c13, c14, c15, c16;

  logic [3:0] cv [16];
  logic [3:0] exp_cells [16];
  int n_assert;
  int n_fail;

  state_demux dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_index(wr_index), .wr_state(wr_state),
    .clr_start(clr_start), .clr_value(clr_value),
    .busy(busy), .err(err),
    .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7), .c8(c8),
    .c9(c9), .c10(c10), .c11(c11), .c12(c12), .c13(c13), .c14(c14),
    .c15(c15), .c16(c16)
  );

  assign cv[0]  = c1;  assign cv[1]  = c2;  assign cv[2]  = c3;  assign cv[3]  = c4;
  assign cv[4]  = c5;  assign cv[5]  = c6;  assign cv[6]  = c7;  assign cv[7]  = c8;
  assign cv[8]  = c9;  assign cv[9]  = c10; assign cv[10] = c11; assign cv[11] = c12;
  assign cv[12] = c13; assign cv[13] = c14; assign cv[14] = c15; assign cv[15] = c16;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_cells(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_c%0d", tag, i + 1), {4'h0, cv[i]}, {4'h0, exp_cells[i]});
    end
  endtask

  task automatic chk_flags(input string tag, input logic e_ready, input logic e_busy,
                           input logic e_err);
    chk({tag, "_wr_ready"}, {7'd0, wr_ready}, {7'd0, e_ready});
    chk({tag, "_busy"},     {7'd0, busy},     {7'd0, e_busy});
    chk({tag, "_err"},      {7'd0, err},      {7'd0, e_err});
  endtask

  task automatic idle_inputs();
    wr_valid  = 1'b0;
    wr_index  = 8'd0;
    wr_state  = 4'h0;
    clr_start = 1'b0;
    clr_value = 4'h0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    for (int i = 0; i < 16; i++) exp_cells[i] = 4'h0;
    idle_inputs();

    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_flags("reset", 1'b1, 1'b0, 1'b0);
    chk_cells("reset");

    // Single in-range write
    wr_valid = 1'b1; wr_index = 8'd3; wr_state = 4'hA;
    tick();
    idle_inputs();
    exp_cells[3] = 4'hA;
    chk_flags("wr3", 1'b1, 1'b0, 1'b0);
    chk_cells("wr3");

    // Out-of-range write: index 20, then boundary index 16
    wr_valid = 1'b1; wr_index = 8'd20; wr_state = 4'h5;
    tick();
    idle_inputs();
    chk_flags("wr20", 1'b1, 1'b0, 1'b1);
    chk_cells("wr20");
    tick();
    chk_flags("wr20_after", 1'b1, 1'b0, 1'b0);
    wr_valid = 1'b1; wr_index = 8'd16; wr_state = 4'h9;
    tick();
    wr_index = 8'd15; wr_state = 4'h6;
    chk_flags("wr16", 1'b1, 1'b0, 1'b1);
    tick();
    idle_inputs();
    exp_cells[15] = 4'h6;
    chk_flags("wr15", 1'b1, 1'b0, 1'b0);
    chk_cells("wr15");

    // Sweep start together with a write to cell 0
    clr_start = 1'b1; clr_value = 4'h7;
    wr_valid = 1'b1; wr_index = 8'd0; wr_state = 4'h2;
    tick();
    exp_cells[0] = 4'h2;
    chk_flags("sweep_start", 1'b0, 1'b1, 1'b0);
    chk_cells("sweep_start");
    // Conflicting requests during the sweep must be ignored
    clr_value = 4'h3; wr_index = 8'd5; wr_state = 4'hF;
    for (int k = 1; k <= 16; k++) begin
      if (k == 4) idle_inputs();
      if (k == 2) wr_index = 8'd40;
      tick();
      exp_cells[k-1] = 4'h7;
      chk_flags($sformatf("sweep%0d", k), (k == 16), (k < 16), 1'b0);
      chk_cells($sformatf("sweep%0d", k));
    end
    idle_inputs();

    // Back-to-back writes idx i val i
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1; wr_index = 8'(i); wr_state = 4'(i);
      chk($sformatf("b2b_ready%0d", i), {7'd0, wr_ready}, 8'd1);
      tick();
      exp_cells[i] = 4'(i);
    end
    idle_inputs();
    chk_flags("b2b", 1'b1, 1'b0, 1'b0);
    chk_cells("b2b");

    // Consecutive writes to the same index
    wr_valid = 1'b1; wr_index = 8'd2; wr_state = 4'h9;
    tick();
    wr_state = 4'hC;
    tick();
    idle_inputs();
    exp_cells[2] = 4'hC;
    chk_cells("same_idx");

    // Reset during a sweep after 8 cells are filled
    clr_start = 1'b1; clr_value = 4'hE;
    tick();
    idle_inputs();
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_cells[k-1] = 4'hE;
    end
    chk_flags("sweep_mid", 1'b0, 1'b1, 1'b0);
    chk_cells("sweep_mid");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) exp_cells[i] = 4'h0;
    chk_flags("sweep_abort", 1'b1, 1'b0, 1'b0);
    chk_cells("sweep_abort");

    // Reset wins over a write and a sweep start in the same cycle
    wr_valid = 1'b1; wr_index = 8'd1; wr_state = 4'h3;
    clr_start = 1'b1; clr_value = 4'hB;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    chk_flags("rst_prio", 1'b1, 1'b0, 1'b0);
    chk_cells("rst_prio");
    tick();
    chk_flags("rst_prio_after", 1'b1, 1'b0, 1'b0);
    chk_cells("rst_prio_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
